// File: rtl/counter_checker.sv
// Passive monitor for a WIDTH-bit up/down counter: predicts data from the sampled ce/up, locks on, then flags mismatches.
// Latency: expected/err are registered one cycle after the sampling edge; locked follows the FSM state register.
// Backpressure: none; the monitor only observes and never stalls or drives the counter.
// Optional macro CNT_CHK_RESET_VAL_EN: check the first sample after reset against RESET_VAL.
module counter_checker #(
    parameter int                WIDTH      = 4,
    parameter int                ERR_CNT_W  = 8,
    parameter int                LOCK_CNT   = 2,
    parameter int                MISS_LIMIT = 3,
    parameter logic [WIDTH-1:0]  RESET_VAL  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 ce,
    input  logic                 up,
    input  logic [WIDTH-1:0]     data,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     expected
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    // Control sampled on the previous edge: it describes the transition
    // that produced the data sampled on the current edge.
    logic                 ce_q;
    logic                 up_q;
    // Reference value: last sampled data while syncing, the free-running
    // model value while locked.
    logic [WIDTH-1:0]     model_q;
    logic [MATCH_W-1:0]   match_run;
    logic [MISS_W-1:0]    miss_run;

    logic [WIDTH-1:0]     pred;
    logic                 hit;
    logic [MATCH_W-1:0]   match_run_inc;
    logic [MISS_W-1:0]    miss_run_inc;
    logic                 lock_reached;
    logic                 limit_reached;
    logic                 mismatch;

`ifdef CNT_CHK_RESET_VAL_EN
    // Low only until the first IDLE sample after rst; clr sets it so a
    // restart after clr is never checked against RESET_VAL.
    logic                 first_done;
`endif

    // Prediction of the current sample and the run-length bookkeeping.
    always_comb begin
        pred = model_q;
        if (ce_q) begin
            pred = up_q ? model_q + WIDTH'(1) : model_q - WIDTH'(1);
        end
        hit           = (data == pred);
        match_run_inc = match_run + MATCH_W'(1);
        miss_run_inc  = miss_run + MISS_W'(1);
        lock_reached  = hit && (match_run_inc == MATCH_W'(LOCK_CNT));
        limit_reached = !hit && (miss_run_inc == MISS_W'(MISS_LIMIT));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; clr overrides every transition.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_SYNC;
                ST_SYNC:   if (lock_reached)  state_nxt = ST_LOCKED;
                ST_LOCKED: if (limit_reached) state_nxt = ST_SYNC;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode: lock flag and which samples count as errors.
    always_comb begin
        locked   = (state == ST_LOCKED);
        mismatch = 1'b0;
        case (state)
            ST_LOCKED: mismatch = !hit;
`ifdef CNT_CHK_RESET_VAL_EN
            ST_IDLE:   mismatch = !first_done && (data != RESET_VAL);
`endif
            default:   mismatch = 1'b0;
        endcase
    end

    // Datapath: model reference, run counters, err pulse and error count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q      <= 1'b0;
            up_q      <= 1'b0;
            model_q   <= '0;
            match_run <= '0;
            miss_run  <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
            expected  <= '0;
        end else if (clr) begin
            match_run <= '0;
            miss_run  <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            ce_q <= ce;
            up_q <= up;
            err  <= mismatch;
            if (mismatch && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    model_q   <= data;
                    match_run <= '0;
                    miss_run  <= '0;
                end
                ST_SYNC: begin
                    // Re-seed from the raw sample every cycle; on lock this
                    // is also the seed of the free-running model.
                    model_q   <= data;
                    expected  <= pred;
                    miss_run  <= '0;
                    if (hit && !lock_reached) begin
                        match_run <= match_run_inc;
                    end else begin
                        match_run <= '0;
                    end
                end
                ST_LOCKED: begin
                    expected <= pred;
                    if (limit_reached) begin
                        // Dropping back to SYNC: reference becomes raw data again.
                        model_q   <= data;
                        match_run <= '0;
                        miss_run  <= '0;
                    end else begin
                        // Model advances regardless of the sample so a bad
                        // sample cannot re-seed it.
                        model_q  <= pred;
                        miss_run <= hit ? '0 : miss_run_inc;
                    end
                end
                default: begin
                    match_run <= '0;
                    miss_run  <= '0;
                end
            endcase
        end
    end

`ifdef CNT_CHK_RESET_VAL_EN
    // Arms the reset-value check for exactly one sample after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_done <= 1'b0;
        end else begin
            first_done <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Passive receiving-end monitor for the 4-bit up/down counter interface (ce, up, data).
- Samples the counter's control inputs and output every clock and predicts the next data value.
- Locks onto the stream, flags every mismatch, and keeps a saturating error count.
- Instantiated beside the counter in simulation benches and FPGA self-test builds; it drives nothing back into the counter.

Parameters:
- WIDTH, 4, width of the counter data bus.
- ERR_CNT_W, 8, width of the saturating error counter.
- LOCK_CNT, 2, consecutive matching samples required in SYNC before entering LOCKED (>=1).
- MISS_LIMIT, 3, consecutive mismatches in LOCKED that drop lock and return to SYNC (>=1).
- RESET_VAL, 0, counter reset value; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear: return to IDLE and zero err_cnt.
- ce  in  1  counter enable as seen by the counter.
- up  in  1  counter direction (1 = increment, 0 = decrement).
- data  in  WIDTH  counter output.
- locked  out  1  checker is in LOCKED.
- err  out  1  one-cycle mismatch pulse.
- err_cnt  out  ERR_CNT_W  saturating mismatch count.
- expected  out  WIDTH  predicted data for the current cycle.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE; locked, err, err_cnt, expected and all internal registers are 0.
- Priority is rst > clr > normal operation.
- clr=1 forces state=IDLE, err_cnt=0, err=0, locked=0 on the next edge.
- Counter model: next = ce ? (up ? cur+1 : cur-1) : cur, modulo 2^WIDTH. Wrap f->0 and 0->f is legal.
- Each posedge registers ce_q and up_q (the sampled ce and up). pred = model(ref, ce_q, up_q).
  - In SYNC, ref = previously sampled data.
  - In LOCKED, ref = the internal model value, so a corrupted sample cannot re-seed the model.
- expected = pred, registered and visible the cycle after the sampling edge.
- IDLE: first edge after rst/clr release captures data, ce and up; go to SYNC with match_run=0.
- SYNC:
  - data==pred: match_run++.
  - Otherwise: match_run=0 and re-seed from data.
  - Reaching match_run==LOCK_CNT: go to LOCKED, set locked=1, seed the model with data.
  - No err pulses are generated in SYNC.
- LOCKED:
  - data==pred: miss_run=0.
  - Otherwise: err=1 for exactly one cycle (registered, one cycle after the sampling edge), err_cnt increments and saturates at all-ones, miss_run++.
  - miss_run==MISS_LIMIT: go to SYNC, locked=0, match_run=0.
  - The model always advances with ce_q/up_q, whether or not the sample matched.
- ce held low: pred=ref, so a held value is never an error.
- Latency: with LOCK_CNT=2, locked rises after the 3rd sampling edge following reset release (IDLE edge plus 2 matches).
- Mismatch in the cycle where miss_run reaches MISS_LIMIT: err still pulses and err_cnt still increments.

Optional Feature:
- Macro CNT_CHK_RESET_VAL_EN.
- When defined: the IDLE-state sample taken on the first edge after rst deasserts (not after clr) is compared to RESET_VAL. A mismatch pulses err and increments err_cnt; the state still goes to SYNC.
- When undefined: the IDLE-state sample is never checked and any start value is accepted.

Test Plan:
- Reset value 0, ce=1, up=0: data 0,f,e,d... -> locked=1 after the 3rd edge, err never asserted, expected tracks f,e,d.
- LOCKED with up=1 from e: data e,f,0,1 -> no err (wrap-around accepted), err_cnt=0.
- ce=0 for 4 cycles at value 5, then ce=1 up=1 and data forced to 5 instead of 6 -> single-cycle err, err_cnt=1, locked stays 1.
- Three consecutive corrupted samples in LOCKED -> err high for 3 cycles, err_cnt=3, locked falls to 0; clean stream afterwards -> locked returns after 2 matches.
- ERR_CNT_W=2 with 5 injected mismatches -> err_cnt=3 (saturated); clr pulse -> err_cnt=0, locked=0.
- rst asserted mid-LOCKED between clock edges -> locked, err, err_cnt, expected go to 0 immediately, without waiting for a clock edge. With CNT_CHK_RESET_VAL_EN and RESET_VAL=0, first sample 3 -> err pulse, err_cnt=1.
